// File: rtl/sseg_display_arbiter_if.sv
// Bus between the display requesters and sseg_display_arbiter: requests and
// per-requester digit nibbles in; grant, frame pulse and display pins out.
interface sseg_display_arbiter_if #(
    parameter int NREQ = 2,
    parameter int NDIG = 4
);
    logic [NREQ-1:0]        req;
    logic [NREQ*NDIG*4-1:0] digits;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   frame_done;
    logic [NDIG-1:0]        an;
    logic [7:0]             sseg;

    modport master (output req, digits, input gnt, busy, frame_done, an, sseg);
    modport slave  (input req, digits, output gnt, busy, frame_done, an, sseg);
endinterface

// File: rtl/sseg_display_arbiter.sv
// Shares one multiplexed 7-segment display among NREQ requesters via req/gnt.
// Define DISP_ROUND_ROBIN_EN for round-robin winner selection (default: fixed priority).
module sseg_display_arbiter #(
    parameter int NREQ       = 2,
    parameter int NDIG       = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int MAX_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sseg_display_arbiter_if.slave bus
);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNTW = $clog2(SCAN_DIV);
    localparam int OWNW = $clog2(NREQ);
    localparam int FRMW = (MAX_FRAMES > 0) ? $clog2(MAX_FRAMES + 1) : 1;

    localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);
    localparam logic [FRMW-1:0] FRM_MAX   = FRMW'(MAX_FRAMES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001001;
            4'hB:    seg_decode = 7'b0000110;
            4'hC:    seg_decode = 7'b1000111;
            4'hD:    seg_decode = 7'b0001100;
            4'hE:    seg_decode = 7'b0111111;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [CNTW-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            frame_done_q, frame_done_d;
    logic [1:0]      state_q, state_d;
    logic [OWNW-1:0] owner_q, owner_d;
    logic [FRMW-1:0] frame_cnt_q, frame_cnt_d;
    logic            excl_q, excl_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [7:0]      sseg_q, sseg_d;

    logic            slot_tick;
    logic            do_grant;
    logic            found;
    logic [NREQ-1:0] owner_oh, others, elig;
    logic [OWNW-1:0] winner;
    logic [3:0]      dig_sel;

    always_comb begin
        slot_tick    = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d   = slot_tick ? '0 : scan_cnt_q + 1'b1;
        idx_d        = idx_q;
        if (slot_tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        frame_done_d = slot_tick && (idx_q == IDX_LAST);
    end

    // A preempted owner stays ineligible only while someone else is waiting.
    always_comb begin
        owner_oh = NREQ'(1) << owner_q;
        others   = bus.req & ~owner_oh;
        elig     = (excl_q && (|others)) ? others : bus.req;
    end

`ifdef DISP_ROUND_ROBIN_EN
    logic [OWNW-1:0] last_owner_q, last_owner_d;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && elig[(int'(last_owner_q) + k) % NREQ]) begin
                winner = OWNW'((int'(last_owner_q) + k) % NREQ);
                found  = 1'b1;
            end
        end
        last_owner_d = do_grant ? winner : last_owner_q;
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && elig[j]) begin
                winner = OWNW'(j);
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        frame_cnt_d = frame_cnt_q;
        excl_d      = excl_q;
        gnt_d       = gnt_q;
        do_grant    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                do_grant = |bus.req;
            end
            ST_GRANT: begin
                if (frame_done_q && (frame_cnt_q != FRM_MAX)) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
                if (!(|(bus.req & owner_oh))) begin
                    state_d = ST_SWITCH;
                    gnt_d   = '0;
                    excl_d  = 1'b0;
                end else if ((MAX_FRAMES != 0) && (frame_cnt_q == FRM_MAX) && (|others)) begin
                    state_d = ST_SWITCH;
                    gnt_d   = '0;
                    excl_d  = 1'b1;
                end
            end
            ST_SWITCH: begin
                if (slot_tick) begin
                    do_grant = |bus.req;
                    state_d  = ST_IDLE;
                    excl_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                excl_d  = 1'b0;
            end
        endcase
        if (do_grant) begin
            state_d     = ST_GRANT;
            owner_d     = winner;
            gnt_d       = NREQ'(1) << winner;
            frame_cnt_d = '0;
            excl_d      = 1'b0;
        end
        busy_d = |gnt_d;
    end

    // Display pins follow the registered state/index/owner, one cycle behind them.
    always_comb begin
        dig_sel = bus.digits[(int'(owner_q) * NDIG + int'(idx_q)) * 4 +: 4];
        if (state_q == ST_GRANT) begin
            an_d   = ~(NDIG'(1) << idx_q);
            sseg_d = {1'b1, seg_decode(dig_sel)};
        end else begin
            an_d   = '1;
            sseg_d = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            frame_cnt_q  <= '0;
            excl_q       <= 1'b0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            an_q         <= '1;
            sseg_q       <= 8'hFF;
`ifdef DISP_ROUND_ROBIN_EN
            last_owner_q <= OWNW'(NREQ - 1);
`endif
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            state_q      <= state_d;
            owner_q      <= owner_d;
            frame_cnt_q  <= frame_cnt_d;
            excl_q       <= excl_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
`ifdef DISP_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.an         = an_q;
    assign bus.sseg       = sseg_q;
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Scoreboard bench for sseg_display_arbiter: a time-based reference model predicts
// every cycle's pins; a separate monitor pops and compares them.
module tb_sseg_display_arbiter;
    localparam int NREQ  = 2;
    localparam int NDIG  = 4;
    localparam int SD    = 4;
    localparam int MAXF  = 2;
    localparam int FRAME = SD * NDIG;
    localparam int DW    = NREQ * NDIG * 4;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic            fd;
        logic [NDIG-1:0] an;
        logic [7:0]      sseg;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sseg_display_arbiter_if #(.NREQ(NREQ), .NDIG(NDIG)) bus ();

    sseg_display_arbiter #(
        .NREQ(NREQ), .NDIG(NDIG), .SCAN_DIV(SD), .MAX_FRAMES(MAXF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    obs_t sb_q[$];
    int   sb_cyc[$];

    // Reference model: time since reset, holder index (-1 = nobody), blanking flag.
    int      t_loc;
    int      holder;
    bit      switching;
    int      frames;
    int      excluded;
    int      last;
    bit      mvalid = 1'b0;
    obs_t    exp_now;
    logic [DW-1:0] cur_dig;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001001, 7'b0000110,
        7'b1000111, 7'b0001100, 7'b0111111, 7'b1111111
    };

    function automatic void chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, c, act, req_v);
        end
    endfunction

    function automatic int pick_winner(input logic [NREQ-1:0] r);
        bit ok [NREQ];
        int n_other;
        n_other = 0;
        for (int i = 0; i < NREQ; i++) if (r[i] && i != excluded) n_other++;
        for (int i = 0; i < NREQ; i++) ok[i] = r[i] && !(i == excluded && n_other > 0);
`ifdef DISP_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) if (ok[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++) if (ok[i]) return i;
`endif
        return -1;
    endfunction

    // Advance the model by one clock given this cycle's inputs; exp_now becomes next cycle's pins.
    task automatic model_step(input bit r_rst, input logic [NREQ-1:0] r, input logic [DW-1:0] d);
        obs_t nx;
        int   idx;
        int   w;
        bit   tick;
        if (r_rst) begin
            t_loc = 0; holder = -1; switching = 1'b0; frames = 0; excluded = -1; last = NREQ - 1;
            exp_now = '{gnt: '0, busy: 1'b0, fd: 1'b0, an: '1, sseg: 8'hFF};
            mvalid  = 1'b1;
            return;
        end
        tick  = (t_loc % SD) == SD - 1;
        idx   = (t_loc / SD) % NDIG;
        nx.fd = ((t_loc + 1) % FRAME) == 0;
        if (holder >= 0) begin
            nx.an   = ~(NDIG'(1) << idx);
            nx.sseg = {1'b1, glyph[d[(holder * NDIG + idx) * 4 +: 4]]};
        end else begin
            nx.an   = '1;
            nx.sseg = 8'hFF;
        end
        if (holder >= 0) begin
            if (!r[holder]) begin
                holder = -1; switching = 1'b1; excluded = -1;
            end else if (MAXF != 0 && frames == MAXF && (r & ~(NREQ'(1) << holder)) != 0) begin
                excluded = holder; holder = -1; switching = 1'b1;
            end else if (exp_now.fd && frames < MAXF) begin
                frames++;
            end
        end else if (!switching || tick) begin
            switching = 1'b0;
            w = pick_winner(r);
            excluded = -1;
            if (w >= 0) begin
                holder = w; last = w; frames = 0;
            end
        end
        nx.gnt  = (holder >= 0) ? NREQ'(1) << holder : '0;
        nx.busy = holder >= 0;
        exp_now = nx;
        t_loc++;
    endtask

    task automatic drive(input bit r_rst, input logic [NREQ-1:0] r);
        if (mvalid) begin
            sb_q.push_back(exp_now);
            sb_cyc.push_back(cyc);
        end
        rst        = r_rst;
        bus.req    = r;
        bus.digits = cur_dig;
        model_step(r_rst, r, cur_dig);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hold(input bit r_rst, input logic [NREQ-1:0] r, input int n, input bit churn);
        for (int i = 0; i < n; i++) begin
            if (churn && $urandom_range(0, 3) == 0)
                cur_dig[$urandom_range(0, NREQ * NDIG - 1) * 4 +: 4] = 4'($urandom);
            drive(r_rst, r);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                obs_t e;
                int   c;
                e = sb_q.pop_front();
                c = sb_cyc.pop_front();
                chk("gnt",        c, 32'(bus.gnt),        32'(e.gnt));
                chk("busy",       c, 32'(bus.busy),       32'(e.busy));
                chk("frame_done", c, 32'(bus.frame_done), 32'(e.fd));
                chk("an",         c, 32'(bus.an),         32'(e.an));
                chk("sseg",       c, 32'(bus.sseg),       32'(e.sseg));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req    = '0;
        bus.digits = '0;
        cur_dig    = '0;
        @(posedge clk);
        #1;
        hold(1'b1, 2'b00, 3, 1'b0);
        hold(1'b0, 2'b00, 40, 1'b0);
        cur_dig[15:0] = 16'hFA1F;
        hold(1'b0, 2'b01, 40, 1'b0);
        hold(1'b0, 2'b00, 20, 1'b0);
        hold(1'b0, 2'b11, 150, 1'b1);
        hold(1'b0, 2'b10, 14, 1'b0);
        hold(1'b1, 2'b10, 1, 1'b0);
        hold(1'b0, 2'b00, 6, 1'b0);
        repeat (60) begin
            hold($urandom_range(0, 30) == 0, NREQ'($urandom), $urandom_range(1, 50), 1'b1);
        end
        hold(1'b0, 2'b00, 20, 1'b0);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        chk("sb_drain", cyc, 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
